// File: rtl/fetch_stage_pkg.sv
// Shared types and helpers for the CARPCore fetch stage.
package fetch_stage_pkg;

   // {pc, next_pc} of the instruction presented to decode
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
   } fetch_state_t;

   // Pipeline control coming from the hazard unit
   typedef struct packed {
      logic stall;
      logic squash;
   } stage_ctrl_t;

   // One instruction buffer entry
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fifo_entry_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // Sequential successor of a fetch address, 32-bit wrapping
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Force a fetch address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, inst} instruction buffer with flush; DEPTH must be a power of 2.
module fetch_fifo
   import fetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  fifo_entry_t              push_data_i,
   input  logic                     pop_i,
   output fifo_entry_t              head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fifo_entry_t        mem_r [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               pop_acc_s;
   logic               push_acc_s;

   // A pop frees a slot in the same cycle, so push+pop on a full buffer is accepted
   assign empty_o    = (count_r == CNT_W'(1'b0));
   assign full_o     = (count_r == CNT_W'(DEPTH));
   assign pop_acc_s  = pop_i & ~empty_o;
   assign push_acc_s = push_i & (~full_o | pop_acc_s);
   assign head_o     = mem_r[rd_ptr_r];
   assign count_o    = count_r;

   // Pointer, occupancy and storage update; flush empties the buffer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_r <= PTR_W'(1'b0);
         wr_ptr_r <= PTR_W'(1'b0);
         count_r  <= CNT_W'(1'b0);
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
         end
      end else if (flush_i) begin
         rd_ptr_r <= PTR_W'(1'b0);
         wr_ptr_r <= PTR_W'(1'b0);
         count_r  <= CNT_W'(1'b0);
      end else begin
         if (push_acc_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_acc_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         count_r <= count_r + CNT_W'(push_acc_s) - CNT_W'(pop_acc_s);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// CARPCore fetch stage: PC ownership, imem req/gnt/rvalid master, instruction buffer
// and fetch->decode pipe register. Optional build macro FETCH_PERF_CNT_EN adds
// saturating bubble/discard performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  stage_ctrl_t   stage_ctrl_i,
   input  logic          redirect_i,
   input  logic [31:0]   redirect_pc_i,
   output logic          imem_req_o,
   output logic [31:0]   imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [31:0]   imem_rdata_i,
   output logic          valid_o,
   output fetch_state_t  fetch_state_o,
   output logic [31:0]   inst_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   perf_bubble_o,
   output logic [31:0]   perf_discard_o
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [31:0]        pc_r;
   logic [CNT_W-1:0]   outstanding_r;
   logic [CNT_W-1:0]   discard_r;
   logic [31:0]        pcq_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   pcq_rd_r;
   logic [PTR_W-1:0]   pcq_wr_r;

   logic [CNT_W-1:0]   fifo_count_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   fifo_entry_t        fifo_head_s;
   fifo_entry_t        fifo_push_data_s;
   logic               fifo_push_s;
   logic               fifo_pop_s;

   logic [SUM_W-1:0]   credit_sum_s;
   logic               credit_s;
   logic               req_s;
   logic               gnt_acc_s;
   logic               resp_live_s;
   logic               push_s;
   logic               drop_s;
   logic [31:0]        redirect_target_s;

   // Credit counts both buffered words and words still in flight so the buffer never overflows
   assign credit_sum_s      = SUM_W'(outstanding_r) + SUM_W'(fifo_count_s);
   assign credit_s          = (credit_sum_s < SUM_W'(FIFO_DEPTH)) &&
                              (outstanding_r < CNT_W'(MAX_OUTSTANDING));
   assign req_s             = rst_ni & credit_s & ~redirect_i;
   assign gnt_acc_s         = req_s & imem_gnt_i;
   assign imem_req_o        = req_s;
   assign imem_addr_o       = pc_r;
   assign redirect_target_s = word_align(redirect_pc_i);

   // Classify each response: delivered to the buffer, or dropped as old-stream / redirected
   always_comb begin
      resp_live_s = 1'b0;
      push_s      = 1'b0;
      drop_s      = 1'b0;
      if (imem_rvalid_i) begin
         resp_live_s = (discard_r == CNT_W'(1'b0));
         push_s      = resp_live_s & ~redirect_i;
         drop_s      = ~push_s;
      end else begin
         resp_live_s = 1'b0;
         push_s      = 1'b0;
         drop_s      = 1'b0;
      end
   end

   assign fifo_pop_s       = ~redirect_i & ~stage_ctrl_i.stall & ~fifo_empty_s;
   assign fifo_push_s      = push_s & (~fifo_full_s | fifo_pop_s);
   assign fifo_push_data_s = '{pc: pcq_r[pcq_rd_r], inst: imem_rdata_i};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (redirect_i),
      .push_i      (fifo_push_s),
      .push_data_i (fifo_push_data_s),
      .pop_i       (fifo_pop_s),
      .head_o      (fifo_head_s),
      .count_o     (fifo_count_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Fetch PC, in-flight count and count of old-stream responses still to be dropped
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_r          <= BOOT_ADDR;
         outstanding_r <= CNT_W'(1'b0);
         discard_r     <= CNT_W'(1'b0);
      end else begin
         outstanding_r <= outstanding_r + CNT_W'(gnt_acc_s) - CNT_W'(imem_rvalid_i);
         if (redirect_i) begin
            pc_r      <= redirect_target_s;
            discard_r <= outstanding_r - CNT_W'(imem_rvalid_i);
         end else begin
            if (gnt_acc_s) begin
               pc_r <= pc_inc(pc_r);
            end
            if (imem_rvalid_i && !resp_live_s) begin
               discard_r <= discard_r - CNT_W'(1'b1);
            end
         end
      end
   end

   // PCs of live granted requests, consumed in order as their words return
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pcq_rd_r <= PTR_W'(1'b0);
         pcq_wr_r <= PTR_W'(1'b0);
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            pcq_r[i] <= 32'h0000_0000;
         end
      end else if (redirect_i) begin
         pcq_rd_r <= PTR_W'(1'b0);
         pcq_wr_r <= PTR_W'(1'b0);
      end else begin
         if (gnt_acc_s) begin
            pcq_r[pcq_wr_r] <= pc_r;
            pcq_wr_r        <= pcq_wr_r + PTR_W'(1'b1);
         end
         if (resp_live_s) begin
            pcq_rd_r <= pcq_rd_r + PTR_W'(1'b1);
         end
      end
   end

   // Fetch->decode pipe register; redirect kills it even while stalled
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o       <= 1'b0;
         fetch_state_o <= '{pc: 32'h0000_0000, next_pc: 32'h0000_0000};
         inst_o        <= 32'h0000_0000;
      end else if (redirect_i) begin
         valid_o <= 1'b0;
      end else if (!stage_ctrl_i.stall) begin
         valid_o <= ~fifo_empty_s & ~stage_ctrl_i.squash;
         if (!fifo_empty_s) begin
            fetch_state_o <= '{pc: fifo_head_s.pc, next_pc: pc_inc(fifo_head_s.pc)};
            inst_o        <= fifo_head_s.inst;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating counters: unstalled cycles with nothing to hand over, and dropped words
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_bubble_o  <= 32'h0000_0000;
         perf_discard_o <= 32'h0000_0000;
      end else begin
         if (!stage_ctrl_i.stall && fifo_empty_s && (perf_bubble_o != 32'hFFFF_FFFF)) begin
            perf_bubble_o <= perf_bubble_o + 32'd1;
         end
         if (drop_s && (perf_discard_o != 32'hFFFF_FFFF)) begin
            perf_discard_o <= perf_discard_o + 32'd1;
         end
      end
   end
`endif

endmodule
